// File: rtl/alu_issue_stage.sv
// Operand/issue stage for the 32-bit combinational ALU: register file, one-deep
// EX stage with result forwarding, and writeback of the ALU result one edge later.
module alu_issue_stage #(
    parameter int DW    = 32,
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_opcode,
    input  logic [DW-1:0] alu_y,
    output logic          wb_valid,
    output logic [AW-1:0] wb_rd,
    output logic [DW-1:0] wb_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    logic [DW-1:0] regs_q [NREGS];
    logic [DW-1:0] regs_d [NREGS];

    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic [3:0]    alu_op_q, alu_op_d;
    logic [AW-1:0] ex_rd_q;
    logic          ex_valid_q;
    logic          wb_valid_q;
    logic [AW-1:0] wb_rd_q;
    logic [DW-1:0] wb_data_q;

    logic accept;

    // A direct load steals the cycle from issue.
    assign in_ready = ~ld_en;
    assign accept   = in_valid & in_ready;

    // The command in EX has not been written back yet, so its result comes
    // straight from the ALU output instead of the register file.
    function automatic logic [DW-1:0] src(input logic [AW-1:0] r);
        if (ex_valid_q && ex_rd_q == r)
            return alu_y;
        return regs_q[r];
    endfunction

    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign a default
        // first, so every path drives every output and no latch is inferred.
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        if (accept) begin
            alu_a_d  = src(in_rs1);
            alu_b_d  = src(in_rs2);
            alu_op_d = in_op;
        end
    end

    // Load is applied after writeback so it wins on a same-register collision.
    always_comb begin
        regs_d = regs_q;
        if (ex_valid_q)
            regs_d[ex_rd_q] = alu_y;
        if (ld_en)
            regs_d[ld_addr] = ld_data;
    end

    // NOTE: the register file is small and architecturally visible, so it is
    // reset along with the pipeline state rather than left uninitialised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            ex_rd_q    <= '0;
            ex_valid_q <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            ex_valid_q <= accept;
            if (accept)
                ex_rd_q <= in_rd;
            wb_valid_q <= ex_valid_q;
            if (ex_valid_q) begin
                wb_rd_q   <= ex_rd_q;
                wb_data_q <= alu_y;
            end
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign dbg_data   = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed-vector bench for alu_issue_stage; a behavioural ALU closes the loop
// from alu_a/alu_b/alu_opcode back to alu_y.
module tb_alu_issue_stage;

    localparam int DW = 32;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [AW-1:0] in_rd, in_rs1, in_rs2;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic [DW-1:0] alu_a, alu_b;
    logic [3:0]    alu_opcode;
    logic [DW-1:0] alu_y;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    alu_issue_stage #(.DW(DW), .NREGS(8), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_y      (alu_y),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_opcode)
            4'b0000: alu_y = alu_a + alu_b;
            4'b0001: alu_y = alu_a - alu_b;
            4'b1100: alu_y = alu_a + 32'd1;
            4'b1101: alu_y = alu_a - 32'd1;
            default: alu_y = alu_a ^ alu_b;
        endcase
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        dbg_addr = a;
        #1;
        check(tag, dbg_data, exp);
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [AW-1:0] rd,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        #22 rst_n = 1'b1;
        #1;

        // Reset state
        check("rst_alu_a", alu_a, 0);
        check("rst_wb_valid", {31'd0, wb_valid}, 0);
        dbg(3'd3, 0, "rst_r3");
        check("rst_in_ready", {31'd0, in_ready}, 1);

        // 1. Simple ADD
        load(3'd1, 32'd5);
        load(3'd2, 32'd3);
        issue(4'b0000, 3'd3, 3'd1, 3'd2);
        step();
        in_valid = 1'b0;
        check("t1_alu_a", alu_a, 5);
        check("t1_alu_b", alu_b, 3);
        check("t1_opcode", {28'd0, alu_opcode}, 0);
        step();
        check("t1_wb_valid", {31'd0, wb_valid}, 1);
        check("t1_wb_rd", {29'd0, wb_rd}, 3);
        check("t1_wb_data", wb_data, 8);
        dbg(3'd3, 8, "t1_dbg_r3");

        // 2. Back-to-back dependency, r3 cleared so only forwarding can give 8
        load(3'd3, 32'd0);
        issue(4'b0000, 3'd3, 3'd1, 3'd2);
        step();
        issue(4'b0001, 3'd4, 3'd3, 3'd1);
        step();
        in_valid = 1'b0;
        check("t2_fwd_alu_a", alu_a, 8);
        check("t2_alu_b", alu_b, 5);
        check("t2_wb1_data", wb_data, 8);
        step();
        check("t2_wb2_valid", {31'd0, wb_valid}, 1);
        check("t2_wb2_rd", {29'd0, wb_rd}, 4);
        check("t2_wb2_data", wb_data, 3);

        // 3. Load stalls issue for two cycles
        issue(4'b0000, 3'd7, 3'd6, 3'd1);
        ld_en = 1'b1; ld_addr = 3'd6; ld_data = 32'd7;
        #1;
        check("t3_ready_low", {31'd0, in_ready}, 0);
        step();
        check("t3_opcode_hold", {28'd0, alu_opcode}, 4'b0001);
        ld_data = 32'd10;
        step();
        check("t3_no_wb", {31'd0, wb_valid}, 0);
        ld_en = 1'b0;
        #1;
        check("t3_ready_high", {31'd0, in_ready}, 1);
        step();
        in_valid = 1'b0;
        check("t3_alu_a", alu_a, 10);
        check("t3_alu_b", alu_b, 5);
        step();
        check("t3_wb_rd", {29'd0, wb_rd}, 7);
        check("t3_wb_data", wb_data, 15);

        // 4. DEC then INC on r0 with forwarding, wrapping both ways
        issue(4'b1101, 3'd0, 3'd0, 3'd0);
        step();
        issue(4'b1100, 3'd0, 3'd0, 3'd0);
        step();
        in_valid = 1'b0;
        check("t4_fwd_alu_a", alu_a, 32'hFFFF_FFFF);
        check("t4_wb_dec", wb_data, 32'hFFFF_FFFF);
        step();
        check("t4_wb_inc", wb_data, 0);
        dbg(3'd0, 0, "t4_dbg_r0");

        // 5. Load collides with writeback to r5
        issue(4'b0000, 3'd5, 3'd1, 3'd2);
        step();
        in_valid = 1'b0;
        load(3'd5, 32'hA5A5_A5A5);
        check("t5_wb_valid", {31'd0, wb_valid}, 1);
        check("t5_wb_rd", {29'd0, wb_rd}, 5);
        check("t5_wb_data", wb_data, 8);
        dbg(3'd5, 32'hA5A5_A5A5, "t5_dbg_r5");

        // 6. Reset between accept and writeback
        issue(4'b0000, 3'd6, 3'd1, 3'd2);
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        check("t6_wb_valid_rst", {31'd0, wb_valid}, 0);
        check("t6_alu_a", alu_a, 0);
        check("t6_alu_b", alu_b, 0);
        step();
        check("t6_no_wb", {31'd0, wb_valid}, 0);
        check("t6_wb_data", wb_data, 0);
        for (int r = 0; r < 8; r++)
            dbg(AW'(r), 0, $sformatf("t6_dbg_r%0d", r));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
